sr_debounce_sync: RTL and testbench

SR_DEBOUNCE_SYNC -- requirements
Module: sr_debounce_sync

---
 rtl/sr_pkg.sv | 30 +++
 rtl/sr_debounce_ch.sv | 127 ++++++++++++
 rtl/sr_debounce_sync.sv | 74 +++++++
 tb/tb_sr_debounce_sync.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pkg
//  Description : Shared definitions for the debounced S/R pulse generator:
//                channel state encoding, synchroniser depth and the default
//                debounce length.
//  Config      : SR_SYNC_3FF_EN -- when defined, the raw-input synchroniser
//                is three flops deep instead of two.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

`ifdef SR_SYNC_3FF_EN
    localparam int N_SYNC = 3;
`else
    localparam int N_SYNC = 2;
`endif

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Per-channel debounce state; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // accepted level 0
        ST_ARM    = 2'd1,   // counting toward accepted level 1
        ST_HELD   = 2'd2,   // accepted level 1
        ST_DISARM = 2'd3    // counting toward accepted level 0
    } ch_state_t;

endpackage : sr_pkg
`default_nettype wire

// File: rtl/sr_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : sr_debounce_ch
//  Description : One debounce channel: N_SYNC-flop synchroniser, four-state
//                debounce FSM with saturating counter, and a registered
//                one-cycle pulse on every accepted rising level.
//  Ports       : clk      - rising-edge clock
//                n_reset  - asynchronous active-low reset
//                btn      - raw asynchronous button level
//                pulse    - one-cycle pulse, registered ARM->HELD transition
//  Config      : SR_SYNC_3FF_EN (via sr_pkg::N_SYNC) sets synchroniser depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_debounce_ch
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn,
    output logic pulse
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [N_SYNC-1:0]  r_sync;
    logic               w_sync;
    ch_state_t          r_state;
    ch_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_rise;
    logic               r_pulse;

    // Synchroniser: the FSM only ever looks at the last stage.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N_SYNC-2:0], btn};
        end
    end

    assign w_sync = r_sync[N_SYNC-1];

    // Counter saturates at DEBOUNCE_CYCLES rather than wrapping.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

    // State, counter and pulse registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_rise;
        end
    end

    // Next-state logic. r_cnt holds the number of consecutive new-level
    // samples already seen, so the level is accepted on the cycle whose
    // sample is the DEBOUNCE_CYCLES-th one (r_cnt == DEBOUNCE_CYCLES-1).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            ST_ARM: begin
                if (!w_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_cnt_last) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_sync) begin
                    w_state_nxt = ST_DISARM;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            ST_DISARM: begin
                // Returning high here re-enters HELD without a new pulse.
                if (w_sync) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: only the ARM->HELD transition produces a pulse.
    always_comb begin
        w_rise = 1'b0;
        if ((r_state == ST_ARM) && (w_state_nxt == ST_HELD)) begin
            w_rise = 1'b1;
        end
    end

    assign pulse = r_pulse;

endmodule : sr_debounce_ch
`default_nettype wire

// File: rtl/sr_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sr_debounce_sync
//  Description : Debounces two raw buttons into one-cycle S and R pulses for
//                a downstream SR gate. Pulses that land in the same cycle are
//                both suppressed and flagged on conflict.
//  Ports       : clk       - rising-edge clock
//                n_reset   - asynchronous active-low reset
//                s_btn     - raw set request (may bounce)
//                r_btn     - raw reset request (may bounce)
//                S         - one-cycle set pulse
//                R         - one-cycle reset pulse
//                conflict  - one-cycle flag for a suppressed S/R pair
//  Config      : SR_SYNC_3FF_EN -- three-flop synchronisers, latency +1 edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_debounce_sync
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic n_reset,
    input  logic s_btn,
    input  logic r_btn,
    output logic S,
    output logic R,
    output logic conflict
);

    logic w_s_pulse;
    logic w_r_pulse;
    logic r_s;
    logic r_r;
    logic r_conflict;

    sr_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_s (
        .clk     (clk),
        .n_reset (n_reset),
        .btn     (s_btn),
        .pulse   (w_s_pulse)
    );

    sr_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch_r (
        .clk     (clk),
        .n_reset (n_reset),
        .btn     (r_btn),
        .pulse   (w_r_pulse)
    );

    // Only coincident pulses conflict; a channel sitting in HELD emits no
    // pulse and so never blocks the other one.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= w_s_pulse & ~w_r_pulse;
            r_r        <= w_r_pulse & ~w_s_pulse;
            r_conflict <= w_s_pulse &  w_r_pulse;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign conflict = r_conflict;

endmodule : sr_debounce_sync
`default_nettype wire

// File: tb/tb_sr_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_debounce_sync
//  Description : Self-checking bench for sr_debounce_sync with
//                DEBOUNCE_CYCLES=4. Stimulus pushes expected output pulses
//                (edge number and S/R/conflict values) into a queue; a
//                negedge monitor pops and compares each pulse it observes.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sr_debounce_sync;
    import sr_pkg::*;

    localparam int c_db  = 4;
    // Edges from the first sampling edge to the edge after which S/R is high.
    localparam int c_lat = N_SYNC + c_db;

    typedef struct {
        int   edge_n;
        logic s;
        logic r;
        logic c;
    } exp_t;

    logic clk      = 1'b0;
    logic n_reset  = 1'b0;
    logic s_btn    = 1'b0;
    logic r_btn    = 1'b0;
    logic S;
    logic R;
    logic conflict;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Downstream SR gate model (its own reset tied inactive).
    logic q = 1'b0;
    logic qbar;
    assign qbar = ~q;
    always @(posedge clk) begin
        if (S)      q <= 1'b1;
        else if (R) q <= 1'b0;
    end

    sr_debounce_sync #(
        .DEBOUNCE_CYCLES (c_db)
    ) u_dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .s_btn    (s_btn),
        .r_btn    (r_btn),
        .S        (S),
        .R        (R),
        .conflict (conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed pulse must match the head of the queue.
    always @(negedge clk) begin
        if (S || R || conflict) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse edge=%0d got S=%b R=%b conflict=%b required no pulse",
                         cyc, S, R, conflict);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.edge_n != cyc || mon_e.s !== S || mon_e.r !== R || mon_e.c !== conflict) begin
                    n_errors++;
                    $display("FAIL pulse edge=%0d S=%b R=%b conflict=%b required edge=%0d S=%b R=%b conflict=%b",
                             cyc, S, R, conflict, mon_e.edge_n, mon_e.s, mon_e.r, mon_e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic push(input int edge_n, input logic s, input logic r, input logic c);
        exp_t e;
        e.edge_n = edge_n;
        e.s      = s;
        e.r      = r;
        e.c      = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at edge=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        int pat[7];
        pat = '{1, 0, 1, 1, 1, 1, 1};

        // Reset state.
        idle(3);
        check("reset_S", int'(S), 0);
        check("reset_R", int'(R), 0);
        check("reset_conflict", int'(conflict), 0);
        check("reset_s_state", int'(u_dut.u_ch_s.r_state), int'(ST_IDLE));
        n_reset = 1'b1;
        idle(3);

        // Clean press on s: pulse c_lat edges after the first sampling edge.
        s_btn = 1'b1;
        e0 = cyc + 1;
        push(e0 + c_lat, 1'b1, 1'b0, 1'b0);
        idle(14);
        s_btn = 1'b0;
        idle(12);
        check("clean_drained", exp_q.size(), 0);

        // Glitch on r: three samples high is too short.
        r_btn = 1'b1;
        idle(3);
        r_btn = 1'b0;
        idle(10);
        check("glitch_r_idle", int'(u_dut.u_ch_r.r_state), int'(ST_IDLE));
        check("glitch_drained", exp_q.size(), 0);

        // Bounce: last rising sample is at e0+2.
        s_btn = pat[0][0];
        e0 = cyc + 1;
        push(e0 + 2 + c_lat, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            s_btn = pat[i][0];
        end
        idle(14);
        s_btn = 1'b0;
        idle(12);
        check("bounce_drained", exp_q.size(), 0);

        // Simultaneous press: both suppressed, conflict once.
        s_btn = 1'b1;
        r_btn = 1'b1;
        e0 = cyc + 1;
        push(e0 + c_lat, 1'b0, 1'b0, 1'b1);
        idle(14);
        s_btn = 1'b0;
        r_btn = 1'b0;
        idle(12);
        check("simul_drained", exp_q.size(), 0);

        // Reset mid-debounce: asserted before edge e0+3, released before e0+5.
        s_btn = 1'b1;
        e0 = cyc + 1;
        idle(3);
        n_reset = 1'b0;
        #1;
        check("midrst_state", int'(u_dut.u_ch_s.r_state), int'(ST_IDLE));
        check("midrst_cnt", int'(u_dut.u_ch_s.r_cnt), 0);
        idle(2);
        n_reset = 1'b1;
        e1 = cyc + 1;
        check("midrst_release_edge", e1, e0 + 5);
        push(e1 + c_lat, 1'b1, 1'b0, 1'b0);
        idle(14);
        s_btn = 1'b0;
        idle(12);
        check("midrst_drained", exp_q.size(), 0);

        // Press into the latch: S sets it, then R clears it.
        s_btn = 1'b1;
        e0 = cyc + 1;
        push(e0 + c_lat, 1'b1, 1'b0, 1'b0);
        idle(10);
        check("latch_set_Q", int'(q), 1);
        check("latch_set_Qbar", int'(qbar), 0);
        s_btn = 1'b0;
        idle(12);
        r_btn = 1'b1;
        e0 = cyc + 1;
        push(e0 + c_lat, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("latch_rst_Q", int'(q), 0);
        check("latch_rst_Qbar", int'(qbar), 1);
        r_btn = 1'b0;
        idle(12);
        check("latch_drained", exp_q.size(), 0);

        // Reset clears a live S pulse without waiting for clk.
        s_btn = 1'b1;
        idle(c_lat);
        @(posedge clk);
        #2;
        check("async_pre_S", int'(S), 1);
        n_reset = 1'b0;
        #1;
        check("async_clear_S", int'(S), 0);
        @(negedge clk);
        s_btn   = 1'b0;
        n_reset = 1'b1;
        idle(12);
        check("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sr_debounce_sync
`default_nettype wire
